// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request/store fields in, grant and response out.
// The lock input exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
`ifdef DMEM_ARB_LOCK_EN
    logic        lock;
`endif

    modport master (
        output req, we, addr, wdata, be,
`ifdef DMEM_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
`ifdef DMEM_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port word memory with single-cycle
// sub-word merge and registered response. Optional bus lock FSM: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        return (old_w & ~byte_mask(be)) | (new_w & byte_mask(be));
    endfunction

    logic        prio;
    logic        allow0, allow1;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        any_gnt;
    logic        we_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;
    logic        in_range;

    logic        rvalid0_p1, rvalid1_p1;
    logic        err0_p1, err1_p1;
    logic [31:0] rdata0_p1, rdata1_p1;

`ifdef DMEM_ARB_LOCK_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0] lock_st;

    // A held lock excludes the other requester regardless of prio
    assign allow0 = (lock_st != ST_LOCK1);
    assign allow1 = (lock_st != ST_LOCK0);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st <= ST_IDLE;
        end else begin
            case (lock_st)
                ST_IDLE: begin
                    if (gnt0 && m0.lock)      lock_st <= ST_LOCK0;
                    else if (gnt1 && m1.lock) lock_st <= ST_LOCK1;
                end
                ST_LOCK0: if (!m0.lock) lock_st <= ST_IDLE;
                ST_LOCK1: if (!m1.lock) lock_st <= ST_IDLE;
                default:  lock_st <= ST_IDLE;
            endcase
        end
    end
`else
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    // Stage p0: combinational grant, address select and store merge
    assign req0    = m0.req && allow0;
    assign req1    = m1.req && allow1;
    assign gnt0    = !rst && req0 && (!req1 || !prio);
    assign gnt1    = !rst && req1 && (!req0 || prio);
    assign any_gnt = gnt0 || gnt1;

    // With no grant the bus idles on m0's address
    assign we_s    = gnt1 ? m1.we    : m0.we;
    assign addr_s  = gnt1 ? m1.addr  : m0.addr;
    assign wdata_s = gnt1 ? m1.wdata : m0.wdata;
    assign be_s    = gnt1 ? m1.be    : m0.be;

    assign in_range  = (addr_s >> 2) < 32'(DEPTH);
    assign mem_addr  = {{(32-AW){1'b0}}, addr_s[AW+1:2]};
    assign mem_wdata = merge_word(mem_rdata, wdata_s, be_s);
    assign mem_we    = any_gnt && we_s && in_range && (be_s != 4'b0000);

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    // Stage p1: registered response, one cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            prio       <= 1'b0;
            rvalid0_p1 <= 1'b0;
            rvalid1_p1 <= 1'b0;
            err0_p1    <= 1'b0;
            err1_p1    <= 1'b0;
            rdata0_p1  <= 32'h0;
            rdata1_p1  <= 32'h0;
        end else begin
            rvalid0_p1 <= gnt0;
            rvalid1_p1 <= gnt1;
            if (gnt0) begin
                prio    <= 1'b1;
                err0_p1 <= !in_range;
                if (!in_range)   rdata0_p1 <= 32'h0;
                else if (!we_s)  rdata0_p1 <= mem_rdata;
            end
            if (gnt1) begin
                prio    <= 1'b0;
                err1_p1 <= !in_range;
                if (!in_range)   rdata1_p1 <= 32'h0;
                else if (!we_s)  rdata1_p1 <= mem_rdata;
            end
        end
    end

    assign m0.rvalid = rvalid0_p1;
    assign m0.err    = err0_p1;
    assign m0.rdata  = rdata0_p1;
    assign m1.rvalid = rvalid1_p1;
    assign m1.err    = err1_p1;
    assign m1.rdata  = rdata1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory on the mem_* side.
// Lock scenarios compile only with DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_init;
    logic [31:0] mem [0:1023];

    int nchecks = 0;
    int nerrors = 0;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter #(.DEPTH(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'd1024) mem_rdata = mem[mem_addr[9:0]];
    end

    // Word k preloads to 0xA000_0000 | k, except word 5
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hA000_0000 | k;
            mem[5] <= 32'h1122_3344;
        end else if (mem_we && mem_addr < 32'd1024) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.be = be;
    endtask

    task automatic set1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.be = be;
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        m0_if.lock = 1'b0;
        m1_if.lock = 1'b0;
`endif
        set0(1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF);
        set1(1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        tick;
        mem_init = 1'b0;
        tick;
        check("rst_gnt0", {31'b0, m0_if.gnt}, 32'd0);
        check("rst_gnt1", {31'b0, m1_if.gnt}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_rvalid0", {31'b0, m0_if.rvalid}, 32'd0);
        check("rst_rvalid1", {31'b0, m1_if.rvalid}, 32'd0);
        check("rst_rdata0", m0_if.rdata, 32'h0);
        check("rst_rdata1", m1_if.rdata, 32'h0);
        check("rst_err0", {31'b0, m0_if.err}, 32'd0);

        // Contention: both load continuously
        rst = 1'b0;
        set0(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        check("c1_gnt0", {31'b0, m0_if.gnt}, 32'd1);
        check("c1_gnt1", {31'b0, m1_if.gnt}, 32'd0);
        check("c1_mem_addr", mem_addr, 32'd2);
        tick;
        check("c1_rvalid0", {31'b0, m0_if.rvalid}, 32'd1);
        check("c1_rdata0", m0_if.rdata, 32'hA000_0002);
        check("c1_rvalid1", {31'b0, m1_if.rvalid}, 32'd0);
        check("c2_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        check("c2_gnt0", {31'b0, m0_if.gnt}, 32'd0);
        check("c2_mem_addr", mem_addr, 32'd3);
        tick;
        check("c2_rvalid1", {31'b0, m1_if.rvalid}, 32'd1);
        check("c2_rdata1", m1_if.rdata, 32'hA000_0003);
        check("c2_rvalid0", {31'b0, m0_if.rvalid}, 32'd0);
        check("c3_gnt0", {31'b0, m0_if.gnt}, 32'd1);
        tick;
        check("c3_rvalid0", {31'b0, m0_if.rvalid}, 32'd1);
        check("c4_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        tick;
        check("c4_rvalid1", {31'b0, m1_if.rvalid}, 32'd1);

        // Partial store to word 5, lane 2
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set0(1'b1, 1'b1, 32'h14, 32'h00AA_0000, 4'b0100);
        #1;
        check("ps_gnt0", {31'b0, m0_if.gnt}, 32'd1);
        check("ps_mem_we", {31'b0, mem_we}, 32'd1);
        check("ps_mem_addr", mem_addr, 32'd5);
        check("ps_mem_wdata", mem_wdata, 32'h11AA_3344);
        tick;
        check("ps_rvalid0", {31'b0, m0_if.rvalid}, 32'd1);
        check("ps_err0", {31'b0, m0_if.err}, 32'd0);
        set0(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        tick;
        check("ps_load_rdata0", m0_if.rdata, 32'h11AA_3344);

        // Out-of-range store from m1
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set1(1'b1, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("oor_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        check("oor_mem_we", {31'b0, mem_we}, 32'd0);
        tick;
        check("oor_rvalid1", {31'b0, m1_if.rvalid}, 32'd1);
        check("oor_err1", {31'b0, m1_if.err}, 32'd1);
        check("oor_rdata1", m1_if.rdata, 32'h0);

        // be = 0 store is a no-op but still acknowledged
        set1(1'b1, 1'b1, 32'h18, 32'hFFFF_FFFF, 4'h0);
        #1;
        check("be0_mem_we", {31'b0, mem_we}, 32'd0);
        tick;
        check("be0_rvalid1", {31'b0, m1_if.rvalid}, 32'd1);
        check("be0_err1", {31'b0, m1_if.err}, 32'd0);
        set1(1'b1, 1'b0, 32'h18, 32'h0, 4'hF);
        tick;
        check("be0_load_rdata1", m1_if.rdata, 32'hA000_0006);

        // Back-to-back store then load, same address
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set0(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        tick;
        check("b2b_store_rvalid0", {31'b0, m0_if.rvalid}, 32'd1);
        set0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        tick;
        check("b2b_rdata0", m0_if.rdata, 32'hDEAD_BEEF);

        // Idle bus follows m0's address
        set0(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
        set1(1'b0, 1'b1, 32'h30, 32'h0, 4'hF);
        #1;
        check("idle_gnt0", {31'b0, m0_if.gnt}, 32'd0);
        check("idle_mem_we", {31'b0, mem_we}, 32'd0);
        check("idle_mem_addr", mem_addr, 32'd8);
        tick;
        check("idle_rvalid0", {31'b0, m0_if.rvalid}, 32'd0);

        // Reset during a grant cycle suppresses the write and the response
        set0(1'b1, 1'b1, 32'h44, 32'h5555_5555, 4'hF);
        rst = 1'b1;
        #1;
        check("rg_mem_we", {31'b0, mem_we}, 32'd0);
        tick;
        check("rg_rvalid0", {31'b0, m0_if.rvalid}, 32'd0);
        rst = 1'b0;
        set0(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        tick;
        check("rg_rdata0", m0_if.rdata, 32'hA000_0011);

`ifdef DMEM_ARB_LOCK_EN
        // prio now favours m1; m1 takes the bus with lock held
        set0(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        set1(1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        m1_if.lock = 1'b1;
        #1;
        check("lk_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        tick;
        check("lk_hold_gnt0", {31'b0, m0_if.gnt}, 32'd0);
        check("lk_hold_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        tick;
        m1_if.lock = 1'b0;
        #1;
        check("lk_drop_gnt0", {31'b0, m0_if.gnt}, 32'd0);
        tick;
        check("lk_after_gnt0", {31'b0, m0_if.gnt}, 32'd1);
        tick;
        m1_if.lock = 1'b1;
        #1;
        check("lk2_gnt1", {31'b0, m1_if.gnt}, 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m1_if.lock = 1'b0;
        #1;
        check("lk_rst_gnt0", {31'b0, m0_if.gnt}, 32'd1);
        check("lk_rst_gnt1", {31'b0, m1_if.gnt}, 32'd0);
        tick;
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access controller in front of the single-port data memory: word storage with a combinational read and a write on the clock edge. Requester 0 is the CPU load/store path and requester 1 is the program loader/debug port. The arbiter grants one requester per cycle round-robin and merges sub-word stores into the stored word in a single cycle using the combinational read. It returns a registered response one cycle after the grant and flags out-of-range accesses.

## Interface
- DEPTH, 1024, number of 32-bit words in the data memory
- AW, $clog2(DEPTH), width of the word index
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mN_req (N=0,1)  in  1  access request; held until mN_gnt
- mN_we  in  1  1 = store, 0 = load
- mN_addr  in  32  byte address; bits [1:0] ignored
- mN_wdata  in  32  store data, lane-aligned
- mN_be  in  4  byte enables; bit i selects byte i
- mN_gnt  out  1  request accepted this cycle
- mN_rvalid  out  1  one-cycle response pulse, for loads and stores
- mN_rdata  out  32  load data; holds its value between responses
- mN_err  out  1  valid with mN_rvalid; address out of range
- mN_lock  in  1  present only with DMEM_ARB_LOCK_EN
- mem_we  out  1  memory write enable
- mem_addr  out  32  word index, {zeros, addr[AW+1:2]}
- mem_wdata  out  32  merged write word
- mem_rdata  in  32  combinational memory read data

## Operation
- Priority pointer prio: reset 0, meaning m0 wins a tie. After any grant to mN, prio points to the other requester.
- Exactly one grant per cycle when any request is valid. A single requester is granted every cycle, back-to-back.
- mem_addr is driven from the granted requester.
- When no request is granted, mem_addr is driven from m0 and mem_we = 0.
- In range means addr[31:2] < DEPTH.
- Granted in-range store: mask = byte-expanded be.
  - mem_wdata = (mem_rdata & ~mask) | (wdata & mask).
  - mem_we = 1 only if be != 0.
  - be = 0 is acknowledged as a no-op.
- Granted out-of-range access: mem_we = 0. The response carries err = 1 and rdata = 0.
- Loads: mem_rdata is captured into mN_rdata at the grant edge. All byte lanes are returned; be is ignored and extension is done by the requester.
- Response registers: on the edge ending a grant to mN, mN_rvalid <= 1 and mN_err <= out_of_range. Every other rvalid is 0 on that edge.
- Reset values:
  - prio = 0, all rvalid = 0, all err = 0, all rdata = 0.
  - Lock state is IDLE.
  - During rst, all gnt and mem_we are forced to 0.

## Timing
- Grant latency: 0 cycles; gnt is combinational from req, prio and lock state in the same cycle.
- Write commit: at the rising edge that ends the grant cycle.
- Response latency: exactly 1 cycle after gnt. Throughput is 1 access per cycle in total.
- Simultaneous requests alternate m0, m1, m0, … starting from prio.
- A same-address store followed by a load in the next cycle returns the stored data, because the store has committed before the load's combinational read.
- If rst is asserted during a grant cycle, that write is suppressed and no response is issued.

## Configuration
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - mN_lock ports exist and a lock FSM with states IDLE, LOCK0 and LOCK1 is compiled in.
  - IDLE → LOCKn at the edge ending a grant to mN with mN_lock = 1.
  - In LOCKn, only mN may be granted. The other requester waits even if prio favours it.
  - LOCKn → IDLE at the end of any cycle with mN_lock = 0.
  - prio still updates on every grant.
  - rst returns the FSM to IDLE.
- Undefined: no lock ports and no FSM; pure round-robin.

## Test plan
- Reset: hold rst 2 cycles with both req = 1 → gnt = 0, mem_we = 0, rvalid = 0, rdata = 0. The first cycle after release grants m0.
- Contention: both requesters issue loads continuously → grants alternate m0, m1, m0, m1. Each rvalid pulses 1 cycle after its gnt with the correct word.
- Partial store: word 5 = 0x11223344; m0 stores addr 0x14, be = 4'b0100, wdata = 0x00AA0000 → word 5 = 0x11AA3344. A follow-up load returns 0x11AA3344.
- Range and no-op:
  - m1 store to addr 4*DEPTH → mem_we = 0, m1_err = 1, rdata = 0.
  - Store with be = 0 → memory unchanged, rvalid = 1, err = 0.
- Back-to-back, same address: m0 stores 0xDEADBEEF to 0x40, then loads 0x40 next cycle → m0_rdata = 0xDEADBEEF.
- Lock (DMEM_ARB_LOCK_EN): m1 granted with lock = 1 while m0 is requesting → m0 is not granted until the cycle after m1_lock drops. rst asserted mid-lock → IDLE, and m0 is granted first after release.
